// File: rtl/rv_enc_pkg.sv
// Shared RV32I encoding definitions: operation selector, instruction formats,
// opcode and funct fields used by the instruction encoder.
package rv_enc_pkg;

  typedef enum logic [5:0] {
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_ECALL
  } enc_op_t;

  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_SYS, FMT_BAD
  } fmt_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'd0, F3_BNE  = 3'd1, F3_BLT = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5, F3_BLTU = 3'd6, F3_BGEU = 3'd7;
  localparam logic [2:0] F3_ADD  = 3'd0, F3_SLL  = 3'd1, F3_SLT = 3'd2, F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4, F3_SR   = 3'd5, F3_OR  = 3'd6, F3_AND  = 3'd7;
  localparam logic [2:0] F3_B    = 3'd0, F3_H    = 3'd1, F3_W   = 3'd2;
  localparam logic [2:0] F3_BU   = 3'd4, F3_HU   = 3'd5, F3_JALR = 3'd0;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // True when v is representable as an n-bit two's-complement value.
  function automatic logic fits_s(input logic [31:0] v, input int unsigned n);
    logic [31:0] t;
    t = $signed(v) >>> (n - 1);
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/rv_enc_format.sv
// Combinational RV32I encoder: operation plus register/immediate fields to a
// machine word; out-of-range immediates or unknown ops yield a nop and err.
module rv_enc_format
  import rv_enc_pkg::*;
(
  input  logic [5:0]  op_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);
  fmt_t        fmt;
  logic [6:0]  opc;
  logic [6:0]  f7;
  logic [2:0]  f3;
  logic [31:0] word;
  logic        imm_ok;

  always_comb begin
    fmt = FMT_BAD;
    opc = '0;
    f3  = '0;
    f7  = F7_BASE;
    case (enc_op_t'(op_i))
      OP_BEQ:   begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = F3_BEQ;  end
      OP_BNE:   begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = F3_BNE;  end
      OP_BLT:   begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = F3_BLT;  end
      OP_BGE:   begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = F3_BGE;  end
      OP_BLTU:  begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = F3_BLTU; end
      OP_BGEU:  begin fmt = FMT_B;   opc = OPC_BRANCH; f3 = F3_BGEU; end
      OP_ADD:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_ADD;  end
      OP_SUB:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_ADD;  f7 = F7_ALT; end
      OP_SLL:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_SLL;  end
      OP_SLT:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_SLT;  end
      OP_SLTU:  begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_SLTU; end
      OP_XOR:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_XOR;  end
      OP_SRL:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_SR;   end
      OP_SRA:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_SR;   f7 = F7_ALT; end
      OP_OR:    begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_OR;   end
      OP_AND:   begin fmt = FMT_R;   opc = OPC_OP;     f3 = F3_AND;  end
      OP_ADDI:  begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = F3_ADD;  end
      OP_SLTI:  begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = F3_SLT;  end
      OP_SLTIU: begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = F3_SLTU; end
      OP_XORI:  begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = F3_XOR;  end
      OP_ORI:   begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = F3_OR;   end
      OP_ANDI:  begin fmt = FMT_I;   opc = OPC_OPIMM;  f3 = F3_AND;  end
      OP_SLLI:  begin fmt = FMT_SH;  opc = OPC_OPIMM;  f3 = F3_SLL;  end
      OP_SRLI:  begin fmt = FMT_SH;  opc = OPC_OPIMM;  f3 = F3_SR;   end
      OP_SRAI:  begin fmt = FMT_SH;  opc = OPC_OPIMM;  f3 = F3_SR;   f7 = F7_ALT; end
      OP_LUI:   begin fmt = FMT_U;   opc = OPC_LUI;    end
      OP_AUIPC: begin fmt = FMT_U;   opc = OPC_AUIPC;  end
      OP_JAL:   begin fmt = FMT_J;   opc = OPC_JAL;    end
      OP_JALR:  begin fmt = FMT_I;   opc = OPC_JALR;   f3 = F3_JALR; end
      OP_LB:    begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = F3_B;    end
      OP_LH:    begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = F3_H;    end
      OP_LW:    begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = F3_W;    end
      OP_LBU:   begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = F3_BU;   end
      OP_LHU:   begin fmt = FMT_I;   opc = OPC_LOAD;   f3 = F3_HU;   end
      OP_SB:    begin fmt = FMT_S;   opc = OPC_STORE;  f3 = F3_B;    end
      OP_SH:    begin fmt = FMT_S;   opc = OPC_STORE;  f3 = F3_H;    end
      OP_SW:    begin fmt = FMT_S;   opc = OPC_STORE;  f3 = F3_W;    end
      OP_ECALL: begin fmt = FMT_SYS; opc = OPC_SYSTEM; end
      default:  fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    word   = '0;
    imm_ok = 1'b0;
    case (fmt)
      FMT_R: begin
        imm_ok = 1'b1;
        word   = {f7, rs2_i, rs1_i, f3, rd_i, opc};
      end
      FMT_I: begin
        imm_ok = fits_s(imm_i, 12);
        word   = {imm_i[11:0], rs1_i, f3, rd_i, opc};
      end
      FMT_SH: begin
        imm_ok = (imm_i[31:5] == '0);
        word   = {f7, imm_i[4:0], rs1_i, f3, rd_i, opc};
      end
      FMT_S: begin
        imm_ok = fits_s(imm_i, 12);
        word   = {imm_i[11:5], rs2_i, rs1_i, f3, imm_i[4:0], opc};
      end
      FMT_B: begin
        imm_ok = fits_s(imm_i, 13) && !imm_i[0];
        word   = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3, imm_i[4:1], imm_i[11], opc};
      end
      FMT_U: begin
        imm_ok = (imm_i[11:0] == '0);
        word   = {imm_i[31:12], rd_i, opc};
      end
      FMT_J: begin
        imm_ok = fits_s(imm_i, 21) && !imm_i[0];
        word   = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opc};
      end
      FMT_SYS: begin
        imm_ok = 1'b1;
        word   = {25'b0, opc};
      end
      default: ;
    endcase
  end

  assign instr_o = imm_ok ? word : NOP_INSTR;
  assign err_o   = !imm_ok;

endmodule

// File: rtl/rv_instr_encoder.sv
// Registered RV32I encoder stage: valid/ready in and out, sequential imem
// address that stops at the last word, sticky error capture.
module rv_instr_encoder
  import rv_enc_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned BASE_ADDR = 0
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err,
  output logic [5:0]        err_op
);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BASE_ADDR + DEPTH - 1);

  typedef enum logic [1:0] {S_EMPTY, S_LOADED, S_STOP} state_t;

  state_t            state_q;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q, err_d;
  logic [5:0]        err_op_q;
  logic              at_last, out_hs, accept;

  rv_enc_format u_format (
    .op_i    (in_op),
    .rd_i    (in_rd),
    .rs1_i   (in_rs1),
    .rs2_i   (in_rs2),
    .imm_i   (in_imm),
    .instr_o (instr_d),
    .err_o   (err_d)
  );

  assign at_last   = (addr_q == LAST_ADDR);
  assign out_valid = (state_q == S_LOADED);
  assign full      = (state_q == S_STOP);
  assign out_hs    = out_valid && out_ready;
  // The word at the last address is the final one; a bundle accepted
  // alongside its handshake would have no address left and be lost.
  assign in_ready  = !rst && !clear && !full && (!out_valid || out_ready)
                     && !(out_valid && at_last);
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state_q  <= S_EMPTY;
      instr_q  <= '0;
      addr_q   <= FIRST_ADDR;
      err_q    <= 1'b0;
      err_op_q <= '0;
    end else begin
      if (out_hs) begin
        if (at_last) begin
          state_q <= S_STOP;
        end else begin
          state_q <= S_EMPTY;
          addr_q  <= addr_q + ADDR_W'(1);
        end
      end
      if (accept) begin
        state_q <= S_LOADED;
        instr_q <= instr_d;
        if (err_d) begin
          err_q <= 1'b1;
          if (!err_q) err_op_q <= in_op;
        end
      end
    end
  end

  assign out_instr = instr_q;
  assign out_addr  = addr_q;
  assign err       = err_q;
  assign err_op    = err_op_q;

endmodule
